hazard_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage CPU.
- Decides each cycle whether the pipeline advances, freezes, inserts a bubble or flushes IF/ID.
- Drives the hazard select of the control-bubble mux, the PC/IF-ID write enables, the IF/ID flush and a global pipeline hold.
- Sequences multi-cycle data-memory accesses with a latency counter and keeps a saturating stall-cycle counter.

---
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard / stall sequencer for the 5-stage CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegRt_i,
    input  logic [4:0]  IFID_RegRs_i,
    input  logic [4:0]  IFID_RegRt_i,
    input  logic        IFID_UsesRt_i,
    input  logic        branch_taken_i,
    input  logic        dmem_req_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        bubble_o,
    output logic        hold_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [0:0]       ST_RUN      = 1'b0;
    localparam logic [0:0]       ST_MEM_WAIT = 1'b1;
    localparam int               START_INT   = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_START   = CNT_W'(START_INT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic             MEM_MULTI   = (MEM_LAT > 1) ? 1'b1 : 1'b0;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_start;

    assign load_use = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                      ((IDEX_RegRt_i == IFID_RegRs_i) ||
                       (IFID_UsesRt_i && (IDEX_RegRt_i == IFID_RegRt_i)));

    // MEM_WAIT cannot retrigger, so a request still high during release is ignored
    assign mem_start = (state_q == ST_RUN) && dmem_req_i && MEM_MULTI;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_start) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = CNT_START;
                end
            end
            ST_MEM_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if ((hold_o || bubble_o) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Output logic: hold beats load-use, load-use beats branch
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        bubble_o     = 1'b0;
        hold_o       = 1'b0;
        if (!rst_i) begin
            hold_o = mem_start || ((state_q == ST_MEM_WAIT) && (cnt_q != '0));
            if (hold_o) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
            end else if (load_use) begin
                bubble_o     = 1'b1;
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
            end else begin
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl at MEM_LAT = 3, 1, 2, 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, memrd, uses_rt, br, req;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;

    logic [N-1:0] pc_w, ifid_w, flush, bubble, hold;
    logic [15:0]  sc [N];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: each access is remembered by the cycle it started in
    int cyc = 0;
    int acc_start [N];
    bit acc_valid [N];
    int m_stall   [N];
    bit m_start   [N];
    bit m_inc     [N];

    function automatic int lat_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(idex_rt),
        .IFID_RegRs_i(ifid_rs), .IFID_RegRt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
        .branch_taken_i(br), .dmem_req_i(req), .pc_write_o(pc_w[0]),
        .ifid_write_o(ifid_w[0]), .ifid_flush_o(flush[0]), .bubble_o(bubble[0]),
        .hold_o(hold[0]), .stall_cnt_o(sc[0]));

    hazard_ctrl #(.MEM_LAT(1), .CNT_W(4)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(idex_rt),
        .IFID_RegRs_i(ifid_rs), .IFID_RegRt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
        .branch_taken_i(br), .dmem_req_i(req), .pc_write_o(pc_w[1]),
        .ifid_write_o(ifid_w[1]), .ifid_flush_o(flush[1]), .bubble_o(bubble[1]),
        .hold_o(hold[1]), .stall_cnt_o(sc[1]));

    hazard_ctrl #(.MEM_LAT(2), .CNT_W(4)) u_lat2 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(idex_rt),
        .IFID_RegRs_i(ifid_rs), .IFID_RegRt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
        .branch_taken_i(br), .dmem_req_i(req), .pc_write_o(pc_w[2]),
        .ifid_write_o(ifid_w[2]), .ifid_flush_o(flush[2]), .bubble_o(bubble[2]),
        .hold_o(hold[2]), .stall_cnt_o(sc[2]));

    hazard_ctrl #(.MEM_LAT(8), .CNT_W(4)) u_lat8 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memrd), .IDEX_RegRt_i(idex_rt),
        .IFID_RegRs_i(ifid_rs), .IFID_RegRt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
        .branch_taken_i(br), .dmem_req_i(req), .pc_write_o(pc_w[3]),
        .ifid_write_o(ifid_w[3]), .ifid_flush_o(flush[3]), .bubble_o(bubble[3]),
        .hold_o(hold[3]), .stall_cnt_o(sc[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input bit r, input bit mr, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                         input bit b, input bit q);
        rst = r; memrd = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
        uses_rt = ur; br = b; req = q;
    endtask

    // Check every instance mid-cycle, then advance the model across the edge
    task automatic cycle();
        bit lu;
        @(negedge clk);
        lu = memrd && (idex_rt != 5'd0) &&
             ((idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt)));
        for (int k = 0; k < N; k++) begin
            int L;
            bit in_acc, h, b, f, p, st;
            L      = lat_of(k);
            in_acc = acc_valid[k] && ((cyc - acc_start[k]) <= (L - 1));
            if (rst) begin
                st = 0; h = 0; b = 0; f = 0; p = 1;
            end else begin
                st = !in_acc && req && (L > 1);
                h  = in_acc ? ((cyc - acc_start[k]) < (L - 1)) : st;
                b  = !h && lu;
                f  = !h && !lu && br;
                p  = !h && !lu;
            end
            chk($sformatf("ctrl_lat%0d", L),
                {27'd0, pc_w[k], ifid_w[k], flush[k], bubble[k], hold[k]},
                {27'd0, p, p, f, b, h});
            chk($sformatf("stall_lat%0d", L), {16'd0, sc[k]}, m_stall[k]);
            m_start[k] = st;
            m_inc[k]   = !rst && (h || b);
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                acc_valid[k] = 0;
                m_stall[k]   = 0;
            end else begin
                if (m_start[k]) begin
                    acc_valid[k] = 1;
                    acc_start[k] = cyc;
                end
                if (m_inc[k] && (m_stall[k] < 65535)) m_stall[k]++;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            acc_valid[k] = 0; acc_start[k] = 0; m_stall[k] = 0;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        // Reset then idle
        repeat (2) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        // Load-use on rs, on r0, on rt with rt unused, on rt with rt used
        drive(0, 1, 5, 5, 0, 0, 0, 0);  cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);  cycle();
        drive(0, 1, 0, 0, 0, 1, 0, 0);  cycle();
        drive(0, 1, 7, 1, 7, 0, 0, 0);  cycle();
        drive(0, 1, 7, 1, 7, 1, 0, 0);  cycle();

        // Load-use vs branch, then branch alone
        drive(0, 1, 5, 5, 0, 0, 1, 0);  cycle();
        drive(0, 0, 5, 5, 0, 0, 1, 0);  cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);  repeat (10) cycle();

        // Request high for several cycles, with hazards during the hold
        drive(0, 1, 5, 5, 0, 0, 1, 1);  repeat (3) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);  repeat (10) cycle();

        // Back-to-back requests
        drive(0, 0, 0, 0, 0, 0, 0, 1);  repeat (6) cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);  repeat (10) cycle();

        // Reset in the third held cycle of a long access
        drive(0, 0, 0, 0, 0, 0, 0, 1);  cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);  cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);  cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);  repeat (3) cycle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 64) == 0, $urandom % 2, 5'($urandom % 4),
                  5'($urandom % 4), 5'($urandom % 4), $urandom % 2,
                  ($urandom % 3) == 0, ($urandom % 3) != 0);
            cycle();
        end

        // Saturation of the stall counter
        drive(1, 0, 0, 0, 0, 0, 0, 0);  cycle();
        drive(0, 1, 3, 3, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            if ((i % 4096) == 0) chk("sat_bubble", {31'd0, bubble[0]}, 32'd1);
            @(posedge clk);
            #1;
        end
        cyc += 65540;
        for (int k = 0; k < N; k++) m_stall[k] = 65535;
        repeat (3) cycle();
        for (int k = 0; k < N; k++) chk($sformatf("sat_final%0d", k), {16'd0, sc[k]}, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
